// File: rtl/controle_cpu.sv
// Multi-cycle controller for a 16-bit, 8-register machine. Each instruction takes
// four cycles: handshake into IR, decode/operand fetch, external ALU, write-back.
module controle_cpu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  alu_opcode,
  output logic [15:0] alu_rg2,
  output logic [15:0] alu_rg3,
  output logic [6:0]  alu_imm,
  input  logic [15:0] alu_result,
  input  logic        alu_mem_ativa,
  output logic        wb_valid,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        illegal,
  output logic [15:0] retired,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] regs_q [8];
  logic [15:0] retired_q, retired_d;
  logic [15:0] res_q, res_d;
  logic        wb_valid_q, wb_valid_d;
  logic        illegal_q, illegal_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_rg2_q, alu_rg2_d;
  logic [15:0] alu_rg3_q, alu_rg3_d;
  logic [6:0]  alu_imm_q, alu_imm_d;
  logic        reg_we_s;
  logic [2:0]  op_s, rd_s, rs1_s, rs2_s;

  function automatic logic is_illegal(input logic [2:0] op);
    return (op == 3'd6) || (op == 3'd7);
  endfunction

  assign op_s  = ir_q[15:13];
  assign rd_s  = ir_q[12:10];
  assign rs1_s = ir_q[9:7];
  assign rs2_s = ir_q[6:4];

  // Next-state, operand capture and write-back control
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    retired_d  = retired_q;
    res_d      = res_q;
    wb_valid_d = 1'b0;
    illegal_d  = 1'b0;
    alu_op_d   = alu_op_q;
    alu_rg2_d  = alu_rg2_q;
    alu_rg3_d  = alu_rg3_q;
    alu_imm_d  = alu_imm_q;
    reg_we_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        if (is_illegal(op_s)) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          alu_op_d  = op_s;
          alu_rg2_d = regs_q[rs1_s];
          alu_rg3_d = regs_q[rs2_s];
          alu_imm_d = ir_q[6:0];
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d      = alu_result;
        wb_valid_d = alu_mem_ativa;
        state_d    = S_WB;
      end
      S_WB: begin
        // The latched write flag doubles as the register-file write enable.
        reg_we_s  = wb_valid_q;
        retired_d = retired_q + 16'd1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control, IR, ALU operand and write-back registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ir_q       <= 16'h0000;
      retired_q  <= 16'h0000;
      res_q      <= 16'h0000;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      alu_op_q   <= 3'd0;
      alu_rg2_q  <= 16'h0000;
      alu_rg3_q  <= 16'h0000;
      alu_imm_q  <= 7'd0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      retired_q  <= retired_d;
      res_q      <= res_d;
      wb_valid_q <= wb_valid_d;
      illegal_q  <= illegal_d;
      alu_op_q   <= alu_op_d;
      alu_rg2_q  <= alu_rg2_d;
      alu_rg3_q  <= alu_rg3_d;
      alu_imm_q  <= alu_imm_d;
    end
  end

  // Register file: eight general registers, r0 writable like any other
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else if (reg_we_s) begin
      regs_q[rd_s] <= res_q;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign alu_opcode  = alu_op_q;
  assign alu_rg2     = alu_rg2_q;
  assign alu_rg3     = alu_rg3_q;
  assign alu_imm     = alu_imm_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = rd_s;
  assign wb_data     = res_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_controle_cpu.sv
// Scoreboard bench for controle_cpu: directed instructions, a behavioural ALU and
// register model, and a monitor that checks every write-back and illegal pulse.
module tb_controle_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_rg2;
  logic [15:0] alu_rg3;
  logic [6:0]  alu_imm;
  logic [15:0] alu_result;
  logic        alu_mem_ativa;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal;
  logic [15:0] retired;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  logic        alu_we;
  logic        ovr_en;
  logic [15:0] ovr_val;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mreg [8];
  logic [15:0] mret;
  logic [2:0]  lop;
  logic [15:0] lrg2, lrg3;
  logic [6:0]  limm;

  typedef struct {
    logic        ill;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] ret;
  } ev_t;
  ev_t exp_q[$];

  always #10 clk = ~clk;

  controle_cpu dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_opcode(alu_opcode), .alu_rg2(alu_rg2), .alu_rg3(alu_rg3),
    .alu_imm(alu_imm), .alu_result(alu_result), .alu_mem_ativa(alu_mem_ativa),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal),
    .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [6:0] imm);
    case (op)
      3'd0:    return {9'd0, imm};
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_result    = ovr_en ? ovr_val : alu_f(alu_opcode, alu_rg2, alu_rg3, alu_imm);
  assign alu_mem_ativa = alu_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every wb_valid or illegal cycle must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (wb_valid || illegal) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {30'd0, wb_valid, illegal}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("mon_illegal", {31'd0, illegal}, {31'd0, e.ill});
        check("mon_wb_valid", {31'd0, wb_valid}, {31'd0, ~e.ill});
        if (!e.ill) begin
          check("mon_wb_addr", 32'(wb_addr), 32'(e.addr));
          check("mon_wb_data", 32'(wb_data), 32'(e.data));
        end
        check("mon_retired", 32'(retired), 32'(e.ret));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check("ready_timeout", 32'(instr_ready), 32'd1);
  endtask

  task automatic dbg_all();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check($sformatf("dbg_r%0d", i), 32'(dbg_data), 32'(mreg[i]));
    end
    @(negedge clk);
  endtask

  task automatic check_alu_hold(input string name);
    check({name, "_op"},   32'(alu_opcode), 32'(lop));
    check({name, "_rg2"},  32'(alu_rg2),    32'(lrg2));
    check({name, "_rg3"},  32'(alu_rg3),    32'(lrg3));
    check({name, "_imm"},  32'(alu_imm),    32'(limm));
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic we);
    logic [2:0]  op, rd, rs1, rs2;
    logic [15:0] res, oldv;
    logic        legal;
    int          cyc, wb_at;
    ev_t         e;
    op  = ins[15:13];
    rd  = ins[12:10];
    rs1 = ins[9:7];
    rs2 = ins[6:4];
    legal = (op < 3'd6);
    wait_ready();
    alu_we = we;
    res = 16'h0000;
    if (legal) begin
      lop  = op;
      lrg2 = mreg[rs1];
      lrg3 = mreg[rs2];
      limm = ins[6:0];
      res  = ovr_en ? ovr_val : alu_f(op, lrg2, lrg3, limm);
      if (we) begin
        e.ill = 1'b0; e.addr = rd; e.data = res; e.ret = mret;
        exp_q.push_back(e);
      end
    end else begin
      e.ill = 1'b1; e.addr = 3'd0; e.data = 16'h0000; e.ret = mret;
      exp_q.push_back(e);
    end
    oldv = mreg[rd];
    dbg_addr = rd;
    instr_valid = 1'b1;
    instr = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = ~ins;
    cyc = 1;
    wb_at = 0;
    while (!instr_ready && cyc < 20) begin
      if (wb_valid) wb_at = cyc;
      if (cyc == 2 && legal) check_alu_hold("exec_alu");
      if (cyc == 3) check("dbg_before_wb", 32'(dbg_data), 32'(oldv));
      @(negedge clk);
      cyc++;
    end
    check("cycles_per_instr", 32'(cyc), legal ? 32'd4 : 32'd2);
    check("wb_valid_cycle", 32'(wb_at), (legal && we) ? 32'd3 : 32'd0);
    if (legal) begin
      if (we) mreg[rd] = res;
      mret = mret + 16'd1;
    end else begin
      check_alu_hold("illegal_alu_hold");
    end
    check("dbg_after_wb", 32'(dbg_data), 32'(mreg[rd]));
    check("retired", 32'(retired), 32'(mret));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    ev_t         ev;
    logic [15:0] v;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000; dbg_addr = 3'd0;
    alu_we = 1'b1; ovr_en = 1'b0; ovr_val = 16'h0000;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
    mret = 16'h0000; lop = 3'd0; lrg2 = 16'h0000; lrg3 = 16'h0000; limm = 7'd0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check_alu_hold("rst_alu");
    rst_n = 1'b1;
    @(negedge clk);
    dbg_all();

    // LOAD r1, 5
    run_instr(16'h0405, 1'b1);
    check("load_r1_lit", 32'(dbg_data), 32'h0005);
    check("load_retired_lit", 32'(retired), 32'd1);
    // LOAD r2, 3 then ADD r3 = r1 + r2
    run_instr(16'h0803, 1'b1);
    run_instr(16'h2CA0, 1'b1);
    check("add_r3_lit", 32'(dbg_data), 32'h0008);
    check("add_rg2_lit", 32'(alu_rg2), 32'h0005);
    check("add_rg3_lit", 32'(alu_rg3), 32'h0003);
    check("add_op_lit", 32'(alu_opcode), 32'd1);
    // SUB r5 = r3 - r1; XOR r6 with write flag low
    run_instr(16'h5590, 1'b1);
    run_instr(16'hB9D0, 1'b0);
    // illegal opcodes 7 and 6
    run_instr(16'hE000, 1'b1);
    run_instr(16'hC123, 1'b1);
    // back-to-back dependency: OR r0 = r3 | r1, ADD r1 = r0 + r0
    run_instr(16'h8190, 1'b1);
    run_instr(16'h2400, 1'b1);
    check("dep_r1_lit", 32'(dbg_data), 32'h001A);

    // instr_valid held for 10 cycles: only IDLE edges accept
    wait_ready();
    alu_we = 1'b1;
    for (int k = 0; k < 10; k++) begin
      v = {3'd0, 3'(k % 8), 3'd0, 7'(16 + k)};
      instr_valid = 1'b1;
      instr = v;
      check("held_ready", 32'(instr_ready), (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k % 4 == 0) begin
        lop = 3'd0; lrg2 = mreg[0]; lrg3 = mreg[v[6:4]]; limm = v[6:0];
        ev.ill = 1'b0; ev.addr = 3'(k % 8); ev.data = {9'd0, v[6:0]}; ev.ret = mret;
        exp_q.push_back(ev);
        mreg[ev.addr] = ev.data;
        mret = mret + 16'd1;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    wait_ready();
    check_alu_hold("held_alu");
    check("held_retired", 32'(retired), 32'(mret));
    dbg_all();

    // retired wraps from 0xFFFF
    wait_ready();
    force dut.retired_q = 16'hFFFF;
    @(negedge clk);
    release dut.retired_q;
    mret = 16'hFFFF;
    check("forced_retired", 32'(retired), 32'h0000FFFF);
    run_instr(16'h087F, 1'b1);
    check("retired_wrap_lit", 32'(retired), 32'h0000);

    // reset during EXEC of a write of 0x1234 to r4
    wait_ready();
    ovr_en = 1'b1; ovr_val = 16'h1234; alu_we = 1'b1; dbg_addr = 3'd4;
    instr_valid = 1'b1; instr = 16'h1005;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("exec_busy", 32'(instr_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_r4", 32'(dbg_data), 32'h0000);
    check("abort_retired", 32'(retired), 32'h0000);
    check("abort_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ovr_en = 1'b0;
    #1;
    check("ready_after_reset", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
    mret = 16'h0000; lop = 3'd0; lrg2 = 16'h0000; lrg3 = 16'h0000; limm = 7'd0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check_alu_hold("post_reset_alu");
    check("post_reset_retired", 32'(retired), 32'h0000);
    dbg_all();
    run_instr(16'h1005, 1'b1);
    check("post_reset_r4_lit", 32'(dbg_data), 32'h0005);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/controle_cpu.md
CONTROLE_CPU -- requirements
Module: controle_cpu

Interface
REQ-001 The module SHALL have one clock and one asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-002 Port instr_valid  in  1  SHALL mean an instruction is offered.
REQ-003 Port instr_ready  out  1  SHALL mean the controller accepts an instruction this cycle.
REQ-004 Port instr  in  16  SHALL carry the instruction: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [6:0] Imm (Imm and rs2 overlap).
REQ-005 Ports alu_opcode out 3, alu_rg2 out 16, alu_rg3 out 16, alu_imm out 7 SHALL drive the ALU operands.
REQ-006 Ports alu_result in 16 and alu_mem_ativa in 1 SHALL be the ALU result and write-enable flag.
REQ-007 Ports wb_valid out 1, wb_addr out 3, wb_data out 16 SHALL report a register write.
REQ-008 Port illegal  out  1  SHALL pulse for an opcode of 6 or 7.
REQ-009 Port retired  out  16  SHALL count completed legal instructions.
REQ-010 Ports dbg_addr in 3 and dbg_data out 16 SHALL give a combinational debug read of the register file.

Function
REQ-011 The register file SHALL hold 8 x 16-bit registers, all writable, r0 included.
REQ-012 The FSM SHALL have the states IDLE, DECODE, EXEC and WB; instr_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: on instr_valid=1 at a clock edge, instr SHALL be captured into IR and the state SHALL go to DECODE; otherwise it SHALL stay in IDLE.
REQ-014 DECODE with opcode 0-5: the controller SHALL register alu_opcode=IR[15:13], alu_rg2=reg[rs1], alu_rg3=reg[rs2], alu_imm=IR[6:0], then go to EXEC.
REQ-015 DECODE with opcode 6 or 7: illegal SHALL be 1 for exactly one cycle (the cycle after the edge), the state SHALL return to IDLE, with no write and no change to retired; ALU outputs SHALL be unchanged.
REQ-016 EXEC: alu_result and alu_mem_ativa SHALL be latched at the edge leaving EXEC, then the state SHALL go to WB.
REQ-017 WB: wb_valid SHALL equal the latched alu_mem_ativa, with wb_addr=rd and wb_data=latched result.
REQ-018 At the edge leaving WB, reg[rd] SHALL be written if the latched flag is 1, retired SHALL increment (16-bit wrap, 0xFFFF->0x0000), and the state SHALL go to IDLE.
REQ-019 Timing: a handshake at edge E0 SHALL give wb_valid high in the cycle between E2 and E3, a register update at E3, and instr_ready=1 after E3, i.e. 4 cycles per instruction.
REQ-020 Back-to-back: an instruction SHALL read values written by the previous instruction; no bypass is needed because the write lands before the next DECODE.
REQ-021 The ALU operand outputs SHALL hold their values between instructions.
REQ-022 An instr_valid asserted outside IDLE SHALL be ignored, and instr SHALL be re-sampled only on an IDLE handshake.
REQ-023 dbg_data SHALL be reg[dbg_addr] with no latency and SHALL show the new value in the cycle after the write edge.

Reset
REQ-024 With rst_n=0, asynchronously: state=IDLE, all registers=0, IR=0, retired=0, wb_valid=0, illegal=0, alu_opcode=0, alu_rg2=0, alu_rg3=0, alu_imm=0.
REQ-025 Reset in DECODE, EXEC or WB SHALL abort the instruction with no write and no retire; instr_ready SHALL be 1 on the first cycle after rst_n rises.

Verification
REQ-026 Instruction 0x0405 (LOAD, rd=1, Imm=5) with a model ALU returning 5 and mem_ativa=1 -> wb_valid on the 3rd cycle, wb_addr=1, wb_data=0x0005, dbg r1=0x0005, retired=1.
REQ-027 r1=5 and r2=3 preloaded, then ADD 0x2C00|rs1=1|rs2=2 (0x2CA0) -> alu_rg2=5, alu_rg3=3, alu_opcode=1, r3=0x0008 after E3.
REQ-028 Opcode 7 (0xE000) -> illegal pulses 1 cycle, wb_valid stays 0, retired is unchanged, instr_ready returns after 2 cycles.
REQ-029 instr_valid held high for 10 cycles with different instr values in non-IDLE cycles -> only the instructions present at IDLE edges are executed.
REQ-030 rst_n pulsed low during EXEC of a write to r4=0x1234 -> r4=0, retired=0, wb_valid never asserted.
REQ-031 retired preset to 0xFFFF by 65535 instructions (or by a forced test) plus one legal instruction -> retired=0x0000.
